// File: rtl/firebird7_in_gate1_tessent_secure_select_reg.sv
// Key-protected IJTAG select TDR for the gate1 secure scan mux; mux_select/locked_out update 1 tck after ue.
// Lockout counter and LOCKOUT state are built only when FIREBIRD7_SECURE_SELECT_LOCKOUT_EN is defined.
module firebird7_in_gate1_tessent_secure_select_reg #(
  parameter int                   KEY_WIDTH    = 16,
  parameter logic [KEY_WIDTH-1:0] KEY_VALUE    = 16'hA5C3,
  parameter int                   MAX_ATTEMPTS = 3
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  input  logic ijtag_sel,
  input  logic ijtag_ce,
  input  logic ijtag_se,
  input  logic ijtag_ue,
  input  logic ijtag_si,
  output logic ijtag_so,
  output logic mux_select,
  output logic locked_out
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [KEY_WIDTH:0] shift_reg_q, shift_reg_d;
  logic               mux_select_q, mux_select_d;
  logic [3:0]         attempts;
  logic               locked_out_s;
  logic [6:0]         status;
  logic [KEY_WIDTH+7:0] status_ext;
  logic               key_match;

`ifdef FIREBIRD7_SECURE_SELECT_LOCKOUT_EN
  logic [3:0] attempts_q, attempts_d;
  logic       locked_out_q, locked_out_d;
  logic       last_attempt;

  assign attempts     = attempts_q;
  assign locked_out_s = locked_out_q;
  assign last_attempt = (({1'b0, attempts_q} + 5'd1) == 5'(MAX_ATTEMPTS));
`else
  assign attempts     = 4'd0;
  assign locked_out_s = 1'b0;
`endif

  // Status is zero-extended into the scan segment; the key is never read back.
  assign status     = {attempts, locked_out_s, (state_q == ST_UNLOCKED), mux_select_q};
  assign status_ext = {{(KEY_WIDTH+1){1'b0}}, status};
  assign key_match  = (shift_reg_q[KEY_WIDTH:1] == KEY_VALUE);

  always_comb begin
    shift_reg_d = shift_reg_q;
    if (ijtag_sel && ijtag_ce) begin
      shift_reg_d = status_ext[KEY_WIDTH:0];
    end else if (ijtag_sel && ijtag_se) begin
      shift_reg_d = {ijtag_si, shift_reg_q[KEY_WIDTH:1]};
    end
  end

  always_comb begin
    state_d      = state_q;
    mux_select_d = mux_select_q;
`ifdef FIREBIRD7_SECURE_SELECT_LOCKOUT_EN
    attempts_d   = attempts_q;
    locked_out_d = locked_out_q;
`endif
    if (ijtag_sel && ijtag_ue) begin
      case (state_q)
        ST_LOCKED, ST_UNLOCKED: begin
          // A matching key wins even on the final permitted attempt.
          if (key_match) begin
            state_d      = ST_UNLOCKED;
            mux_select_d = shift_reg_q[0];
`ifdef FIREBIRD7_SECURE_SELECT_LOCKOUT_EN
            attempts_d   = 4'd0;
`endif
          end else begin
            state_d      = ST_LOCKED;
            mux_select_d = 1'b0;
`ifdef FIREBIRD7_SECURE_SELECT_LOCKOUT_EN
            if (attempts_q < 4'(MAX_ATTEMPTS)) begin
              attempts_d = attempts_q + 4'd1;
            end
            if (last_attempt) begin
              state_d      = ST_LOCKOUT;
              locked_out_d = 1'b1;
            end
`endif
          end
        end
        ST_LOCKOUT: begin
          mux_select_d = 1'b0;
        end
        default: begin
          state_d      = ST_LOCKED;
          mux_select_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q      <= ST_LOCKED;
      shift_reg_q  <= '0;
      mux_select_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      mux_select_q <= mux_select_d;
    end
  end

`ifdef FIREBIRD7_SECURE_SELECT_LOCKOUT_EN
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      attempts_q   <= 4'd0;
      locked_out_q <= 1'b0;
    end else begin
      attempts_q   <= attempts_d;
      locked_out_q <= locked_out_d;
    end
  end
`endif

  assign ijtag_so   = shift_reg_q[0];
  assign mux_select = mux_select_q;
  assign locked_out = locked_out_s;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_secure_select_reg.sv
// Directed bench for the secure select TDR; expectations follow FIREBIRD7_SECURE_SELECT_LOCKOUT_EN.
module tb_firebird7_in_gate1_tessent_secure_select_reg;

  logic ijtag_tck = 1'b0;
  logic ijtag_reset;
  logic ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic ijtag_so, mux_select, locked_out;

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_secure_select_reg dut (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .ijtag_sel  (ijtag_sel),
    .ijtag_ce   (ijtag_ce),
    .ijtag_se   (ijtag_se),
    .ijtag_ue   (ijtag_ue),
    .ijtag_si   (ijtag_si),
    .ijtag_so   (ijtag_so),
    .mux_select (mux_select),
    .locked_out (locked_out)
  );

  typedef struct {
    logic [15:0] key;
    logic        req;
    logic        upd_sel;
    logic        exp_mux;
    logic        exp_lock;
    logic [6:0]  exp_stat;  // {attempts, locked_out, unlocked, mux_select}
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [15:0] key, input logic req, input logic usel,
                              input logic emux, input logic elock, input logic [6:0] estat);
    vec_t v;
    v.key = key; v.req = req; v.upd_sel = usel;
    v.exp_mux = emux; v.exp_lock = elock; v.exp_stat = estat;
    return v;
  endfunction

  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic shift_in(input logic [16:0] d);
    ijtag_sel = 1'b1;
    ijtag_se  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ijtag_si = d[i];
      tick();
    end
    ijtag_se = 1'b0;
    ijtag_si = 1'b0;
  endtask

  task automatic do_update(input logic s);
    ijtag_sel = s;
    ijtag_ue  = 1'b1;
    tick();
    ijtag_ue  = 1'b0;
    ijtag_sel = 1'b1;
  endtask

  // Capture is issued together with shift enable, so capture priority is exercised every time.
  task automatic capture_out(input string nm, input logic [6:0] st);
    logic [16:0] got;
    ijtag_sel = 1'b1;
    ijtag_ce  = 1'b1;
    ijtag_se  = 1'b1;
    ijtag_si  = 1'b0;
    tick();
    ijtag_ce  = 1'b0;
    got[0]    = ijtag_so;
    for (int i = 1; i < 17; i++) begin
      tick();
      got[i] = ijtag_so;
    end
    ijtag_se = 1'b0;
    check(nm, 32'(got), {25'd0, st});
  endtask

  initial begin
    ijtag_reset = 1'b0;
    ijtag_sel = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;

`ifdef FIREBIRD7_SECURE_SELECT_LOCKOUT_EN
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000_0_1_1));
    tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0001_0_0_0));
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001_0_0_0));
    tbl.push_back(mk(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0010_0_0_0));
    tbl.push_back(mk(16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000_0_1_0));
    tbl.push_back(mk(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0001_0_0_0));
    tbl.push_back(mk(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0010_0_0_0));
    tbl.push_back(mk(16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0011_1_0_0));
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0011_1_0_0));
    tbl.push_back(mk(16'h0003, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0011_1_0_0));
`else
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000_0_1_1));
    tbl.push_back(mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000_0_1_0));
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000_0_1_1));
    tbl.push_back(mk(16'hA5C2, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'h5A3C, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'h25C3, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000_0_0_0));
    tbl.push_back(mk(16'hA5C3, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000_0_1_1));
`endif

    #12;
    check("reset_so",   32'(ijtag_so),   32'd0);
    check("reset_mux",  32'(mux_select), 32'd0);
    check("reset_lock", 32'(locked_out), 32'd0);
    ijtag_reset = 1'b1;
    tick();
    capture_out("reset_capture", 7'd0);

    // Update with ue asserted: outputs must already be old value just before the edge.
    shift_in({16'hA5C3, 1'b1});
    check("pre_update_mux", 32'(mux_select), 32'd0);
    do_update(1'b1);
    check("first_unlock_mux", 32'(mux_select), 32'd1);
    shift_in({16'h0000, 1'b0});
    do_update(1'b1);
    check("relock_mux", 32'(mux_select), 32'd0);

    // Start the table from a clean reset so attempt counts are known.
    ijtag_reset = 1'b0;
    #2;
    ijtag_reset = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      shift_in({tbl[i].key, tbl[i].req});
      do_update(tbl[i].upd_sel);
      check($sformatf("vec%0d_mux", i),  32'(mux_select), 32'(tbl[i].exp_mux));
      check($sformatf("vec%0d_lock", i), 32'(locked_out), 32'(tbl[i].exp_lock));
      capture_out($sformatf("vec%0d_capture", i), tbl[i].exp_stat);
    end

    // Asynchronous reset in the middle of a shift.
    shift_in(17'h1FFFF);
    check("pre_reset_so", 32'(ijtag_so), 32'd1);
    ijtag_sel = 1'b1;
    ijtag_se  = 1'b1;
    ijtag_si  = 1'b1;
    tick();
    tick();
    ijtag_reset = 1'b0;
    #2;
    check("async_reset_so",   32'(ijtag_so),   32'd0);
    check("async_reset_mux",  32'(mux_select), 32'd0);
    check("async_reset_lock", 32'(locked_out), 32'd0);
    ijtag_se    = 1'b0;
    ijtag_si    = 1'b0;
    ijtag_reset = 1'b1;
    tick();
    capture_out("post_reset_capture", 7'd0);
    shift_in({16'hA5C3, 1'b1});
    do_update(1'b1);
    check("post_reset_unlock_mux",  32'(mux_select), 32'd1);
    check("post_reset_unlock_lock", 32'(locked_out), 32'd0);
    capture_out("post_reset_unlock_capture", 7'b0000_0_1_1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_secure_select_reg.md
# firebird7_in_gate1_tessent_secure_select_reg

Key-protected IJTAG select register that drives `mux_select` of the gate1 spare in-system-BIST secure scan mux. It sits directly upstream of that mux: a shift/capture/update TDR whose update stage asserts `mux_select` only after a matching unlock key has been shifted in. Repeated bad keys lock it out until reset. The register's own scan segment is placed in the host IJTAG chain ahead of the mux.

## Interface
- `KEY_WIDTH`, 16: width of unlock key field.
- `KEY_VALUE`, 16'hA5C3: unlock key constant, compared on update.
- `MAX_ATTEMPTS`, 3: mismatching updates tolerated before lockout (1..15).

Ports:
- `ijtag_tck`  in  1  IJTAG clock; all flops on rising edge.
- `ijtag_reset`  in  1  asynchronous active-low reset.
- `ijtag_sel`  in  1  segment select; gates all capture, shift and update.
- `ijtag_ce`  in  1  capture enable.
- `ijtag_se`  in  1  shift enable.
- `ijtag_ue`  in  1  update enable.
- `ijtag_si`  in  1  scan in.
- `ijtag_so`  out  1  scan out = `shift_reg[0]`, combinational from the flop.
- `mux_select`  out  1  registered select to the secure mux.
- `locked_out`  out  1  registered lockout status.

## Operation
- `shift_reg` is KEY_WIDTH+1 bits:
  - bit 0 = select request.
  - bits [KEY_WIDTH:1] = key.
- Shift (sel&se): `shift_reg <= {ijtag_si, shift_reg[KEY_WIDTH:1]}`. LSB exits on `ijtag_so` first.
- Capture (sel&ce): `shift_reg <= {zeros, attempts[3:0], locked_out, state==UNLOCKED, mux_select}`.
  - Zero-extended; bits above KEY_WIDTH are dropped if KEY_WIDTH < 7.
  - The key is never captured back.
- Capture has priority over shift when both are asserted.
- Update (sel&ue) evaluates the pre-edge `shift_reg`. FSM states:
  - LOCKED, reset state.
    - Key match: go to UNLOCKED, `mux_select <= shift_reg[0]`, `attempts <= 0`.
    - Mismatch: `mux_select <= 0`, `attempts <= attempts+1`. Go to LOCKOUT when `attempts+1 == MAX_ATTEMPTS`.
  - UNLOCKED.
    - Key match: `mux_select <= shift_reg[0]`.
    - Mismatch: go to LOCKED, `mux_select <= 0`, count the attempt exactly as in LOCKED.
  - LOCKOUT. Updates are ignored, `mux_select` stays 0, `locked_out=1`. Exit only via `ijtag_reset`.
- `attempts` is a 4-bit saturating counter, never exceeding MAX_ATTEMPTS.
- Update with `ijtag_sel=0` has no effect. Shift/capture in the same cycle as update are legal and independent.

## Timing
- Reset values: `shift_reg=0`, `mux_select=0`, `locked_out=0`, `attempts=0`, state LOCKED. `ijtag_so=0`.
- Reset takes effect immediately and asynchronously. Reset mid-shift discards partial data.
- `mux_select` and `locked_out` change on the rising edge on which update is sampled: 1-cycle latency from `ijtag_ue`.
- `ijtag_so` reflects the new `shift_reg[0]` after each shift/capture edge.
- A key match has priority over the attempt count. A correct key on the last permitted attempt (`attempts == MAX_ATTEMPTS-1`) unlocks.

## Configuration
- `FIREBIRD7_SECURE_SELECT_LOCKOUT_EN`:
  - Defined: attempt counter and LOCKOUT state are built as above.
  - Undefined: the counter and LOCKOUT are removed. A mismatch only returns the block to LOCKED with `mux_select=0`. `locked_out` is tied 0 and captured attempts bits read 0.

## Test plan
- Reset, then capture and shift out 17 bits -> `ijtag_so` sequence all 0; `mux_select=0`.
- Shift {16'hA5C3, 1'b1}, then update -> `mux_select=1` the next cycle. Capture -> bits[2:0]=3'b011.
- While UNLOCKED, shift {16'h0000, 1'b1}, then update -> `mux_select=0`, state LOCKED, `attempts=1`.
- Three mismatching updates -> `locked_out=1`. A following correct key with select=1 -> `mux_select` stays 0.
- Assert `ijtag_reset` low mid-shift after lockout -> all outputs 0, `locked_out=0`. The correct key then unlocks.
- Macro undefined: five mismatches then the correct key -> `locked_out` stays 0 and `mux_select=1`.
